// File: rtl/pfd_charge_pump.sv
// pfd_charge_pump
//   Digital phase-frequency detector with an integrated charge pump for the
//   PLL. Rising edges of the sampled reference and feedback waveforms drive an
//   IDLE/UP/DN/BOTH state machine. The state selects a signed current code for
//   the loop filter. The BOTH state is the anti-backlash overlap: both switches
//   are on for ANTIBL cycles after the lagging edge arrives. A lock detector
//   counts consecutive comparisons whose pulse width is inside LOCK_WIN.
//
// Ports
//   clk          in   clock
//   reset        in   synchronous, active-high reset
//   enable       in   detector enable; low turns the pump off and clears lock
//   ref_in       in   sampled reference waveform
//   fb_in        in   sampled feedback (divided VCO) waveform
//   current_out  out  [18:0] two's-complement pump current code
//   up           out  UP switch active
//   dn           out  DN switch active
//   locked       out  lock indicator
//   pulse_width  out  [15:0] width in cycles of the last completed UP/DN pulse
//
// The FSM state is visible on the outputs: {up, dn} is 00 for IDLE, 10 for UP,
// 01 for DN and 11 for BOTH.
//
// Handshake: there is no valid/ready pair. ref_in and fb_in are sampled on
// every clock edge, and all outputs are registered and valid on every cycle.
module pfd_charge_pump #(
  parameter int I_UP       = 4096,
  parameter int I_DN       = 4096,
  parameter int ANTIBL     = 2,
  parameter int LOCK_WIN   = 3,
  parameter int LOCK_COUNT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        ref_in,
  input  logic        fb_in,
  output logic [18:0] current_out,
  output logic        up,
  output logic        dn,
  output logic        locked,
  output logic [15:0] pulse_width
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DN   = 2'd2,
    ST_BOTH = 2'd3
  } state_t;

  localparam logic [18:0] CUR_UP     = 19'(I_UP);
  localparam logic [18:0] CUR_DN     = 19'(-I_DN);
  localparam logic [18:0] CUR_BOTH   = 19'(I_UP - I_DN);
  localparam logic [3:0]  ANTIBL_C   = 4'(ANTIBL);
  localparam logic [31:0] LOCK_WIN_C = 32'(LOCK_WIN);
  localparam logic [7:0]  LOCK_CNT_C = 8'(LOCK_COUNT);

  state_t      state_q, state_d;
  logic        ref_q, fb_q;
  logic [3:0]  bl_cnt_q, bl_cnt_d;
  logic [15:0] width_q, width_d;
  logic [7:0]  lock_cnt_q, lock_cnt_d;
  logic        locked_q, locked_d;
  logic [15:0] pw_q, pw_d;
  logic [18:0] cur_q, cur_d;
  logic        up_q, up_d;
  logic        dn_q, dn_d;

  logic        ref_rise, fb_rise;
  logic        enter_both;
  logic [15:0] meas_w;
  logic [15:0] width_inc;

  assign ref_rise  = ref_in & ~ref_q;
  assign fb_rise   = fb_in & ~fb_q;
  assign width_inc = (width_q == 16'hFFFF) ? width_q : width_q + 16'd1;

  // Next-state, width and lock logic
  always_comb begin
    state_d    = state_q;
    bl_cnt_d   = bl_cnt_q;
    width_d    = width_q;
    lock_cnt_d = lock_cnt_q;
    locked_d   = locked_q;
    pw_d       = pw_q;
    enter_both = 1'b0;
    meas_w     = '0;

    if (!enable) begin
      state_d    = ST_IDLE;
      bl_cnt_d   = '0;
      width_d    = '0;
      lock_cnt_d = '0;
      locked_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (ref_rise && fb_rise) begin
            enter_both = 1'b1;
            meas_w     = '0;
          end else if (ref_rise) begin
            state_d = ST_UP;
            width_d = 16'd1;
          end else if (fb_rise) begin
            state_d = ST_DN;
            width_d = 16'd1;
          end
        end
        ST_UP: begin
          if (fb_rise) begin
            enter_both = 1'b1;
            meas_w     = width_q;
          end else begin
            width_d = width_inc;
          end
        end
        ST_DN: begin
          if (ref_rise) begin
            enter_both = 1'b1;
            meas_w     = width_q;
          end else begin
            width_d = width_inc;
          end
        end
        ST_BOTH: begin
          // The counter was set to 1 on entry, so the machine leaves after
          // exactly ANTIBL cycles. Edges seen here are intentionally dropped.
          if (bl_cnt_q >= ANTIBL_C) begin
            state_d  = ST_IDLE;
            bl_cnt_d = '0;
          end else begin
            bl_cnt_d = bl_cnt_q + 4'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase

      if (enter_both) begin
        state_d  = ST_BOTH;
        bl_cnt_d = 4'd1;
        width_d  = '0;
        pw_d     = meas_w;
        if ({16'd0, meas_w} <= LOCK_WIN_C) begin
          lock_cnt_d = (lock_cnt_q >= LOCK_CNT_C) ? LOCK_CNT_C : lock_cnt_q + 8'd1;
          if (lock_cnt_d == LOCK_CNT_C) begin
            locked_d = 1'b1;
          end
        end else begin
          lock_cnt_d = '0;
          locked_d   = 1'b0;
        end
      end
    end
  end

  // Outputs are decoded from the next state and registered with it, so they
  // change on the same edge as the state.
  always_comb begin
    cur_d = '0;
    up_d  = 1'b0;
    dn_d  = 1'b0;
    unique case (state_d)
      ST_UP: begin
        cur_d = CUR_UP;
        up_d  = 1'b1;
      end
      ST_DN: begin
        cur_d = CUR_DN;
        dn_d  = 1'b1;
      end
      ST_BOTH: begin
        cur_d = CUR_BOTH;
        up_d  = 1'b1;
        dn_d  = 1'b1;
      end
      default: begin
        cur_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // Edge registers track the inputs even in reset, so an input that is
    // already high when reset is released does not look like a rise.
    ref_q <= ref_in;
    fb_q  <= fb_in;
    if (reset) begin
      state_q    <= ST_IDLE;
      bl_cnt_q   <= '0;
      width_q    <= '0;
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
      pw_q       <= '0;
      cur_q      <= '0;
      up_q       <= 1'b0;
      dn_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      bl_cnt_q   <= bl_cnt_d;
      width_q    <= width_d;
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
      pw_q       <= pw_d;
      cur_q      <= cur_d;
      up_q       <= up_d;
      dn_q       <= dn_d;
    end
  end

  assign current_out = cur_q;
  assign up          = up_q;
  assign dn          = dn_q;
  assign locked      = locked_q;
  assign pulse_width = pw_q;

endmodule

// File: tb/tb_pfd_charge_pump.sv
// Bench for pfd_charge_pump: directed edge patterns with an event-level model
// (timestamps of the leading edge, an overlap countdown, an in-window streak)
// that is compared to the DUT on every cycle, plus literal expectations.
module tb_pfd_charge_pump;

  localparam int I_UP       = 4096;
  localparam int I_DN       = 4096;
  localparam int ANTIBL     = 2;
  localparam int LOCK_WIN   = 3;
  localparam int LOCK_COUNT = 16;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        ref_in;
  logic        fb_in;
  logic [18:0] current_out;
  logic        up;
  logic        dn;
  logic        locked;
  logic [15:0] pulse_width;

  int checks;
  int failures;

  pfd_charge_pump #(
    .I_UP(I_UP), .I_DN(I_DN), .ANTIBL(ANTIBL),
    .LOCK_WIN(LOCK_WIN), .LOCK_COUNT(LOCK_COUNT)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .ref_in(ref_in), .fb_in(fb_in),
    .current_out(current_out), .up(up), .dn(dn), .locked(locked),
    .pulse_width(pulse_width)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- model ----------------
  // lead: 0 none, 1 reference leading, 2 feedback leading
  int cyc_n;
  int lead;
  int start_c;
  int bl_left;
  int streak;
  bit m_locked;
  int m_pw;
  bit m_pr, m_pf;
  bit m_started;

  function automatic void model_event(input int w);
    m_pw    = (w > 65535) ? 65535 : w;
    bl_left = ANTIBL;
    lead    = 0;
    if (w <= LOCK_WIN) begin
      if (streak < LOCK_COUNT) streak++;
    end else begin
      streak = 0;
    end
    m_locked = (streak >= LOCK_COUNT);
  endfunction

  always @(posedge clk) begin
    bit rr, fr;
    cyc_n++;
    m_started = 1'b1;
    rr = ref_in && !m_pr;
    fr = fb_in && !m_pf;
    m_pr = ref_in;
    m_pf = fb_in;
    if (reset) begin
      lead = 0; bl_left = 0; streak = 0; m_locked = 1'b0; m_pw = 0;
    end else if (!enable) begin
      lead = 0; bl_left = 0; streak = 0; m_locked = 1'b0;
    end else if (bl_left > 0) begin
      bl_left--;
    end else if (lead == 0) begin
      if (rr && fr) model_event(0);
      else if (rr) begin lead = 1; start_c = cyc_n; end
      else if (fr) begin lead = 2; start_c = cyc_n; end
    end else if (lead == 1 && fr) begin
      model_event(cyc_n - start_c);
    end else if (lead == 2 && rr) begin
      model_event(cyc_n - start_c);
    end
  end

  // ---------------- scoreboard / compare ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_started) begin
      bit eu, ed;
      int v;
      logic [18:0] ecur;
      eu   = (lead == 1) || (bl_left > 0);
      ed   = (lead == 2) || (bl_left > 0);
      v    = (eu ? I_UP : 0) - (ed ? I_DN : 0);
      ecur = 19'(v);
      check("model_cur", 32'(current_out), 32'(ecur));
      check("model_up", 32'(up), 32'(eu));
      check("model_dn", 32'(dn), 32'(ed));
      check("model_locked", 32'(locked), 32'(m_locked));
      check("model_pw", 32'(pulse_width), 32'(m_pw));
    end
  end

  // ---------------- driver tasks ----------------
  // After cyc returns, DUT outputs reflect the inputs set by the previous call.
  task automatic cyc(input bit r, input bit f);
    @(posedge clk);
    #2;
    ref_in = r;
    fb_in  = f;
  endtask

  // One comparison event; on return the outputs show the BOTH-entry edge.
  task automatic event_(input bit ref_first, input int w);
    repeat (4) cyc(1'b0, 1'b0);
    if (w > 0) begin
      repeat (w) cyc(ref_first, !ref_first);
      if (w >= 2)
        check("mid_pulse_cur", 32'(current_out), ref_first ? 32'd4096 : 32'h7F000);
    end
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
  endtask

  int tbl[14] = '{1, 3, 0, 2, 3, 1, 0, 2, 3, 3, 1, 2, 0, 1};

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    enable   = 1'b1;
    ref_in   = 1'b1;
    fb_in    = 1'b1;

    // Reset with both inputs high, then release: no edge
    repeat (3) cyc(1'b1, 1'b1);
    reset = 1'b0;
    repeat (3) cyc(1'b1, 1'b1);
    check("rel_cur", 32'(current_out), 32'd0);
    check("rel_up", 32'(up), 32'd0);
    check("rel_dn", 32'(dn), 32'd0);
    check("rel_locked", 32'(locked), 32'd0);
    check("rel_pw", 32'(pulse_width), 32'd0);

    // Reference leads by 5
    event_(1'b1, 5);
    check("ref5_pw", 32'(pulse_width), 32'd5);
    check("ref5_cur", 32'(current_out), 32'd0);
    check("ref5_updn", 32'({up, dn}), 32'd3);
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    check("ref5_idle", 32'({up, dn}), 32'd0);

    // Feedback leads by 3
    event_(1'b0, 3);
    check("fb3_pw", 32'(pulse_width), 32'd3);
    check("fb3_locked", 32'(locked), 32'd0);

    // Simultaneous edges
    event_(1'b0, 0);
    check("sim_pw", 32'(pulse_width), 32'd0);
    check("sim_cur", 32'(current_out), 32'd0);
    check("sim_updn", 32'({up, dn}), 32'd3);

    // 14 more in-window events: the 16th in-window entry asserts lock
    for (int i = 0; i < 14; i++) begin
      event_(i[0], tbl[i]);
      check("lock_seq_pw", 32'(pulse_width), 32'(tbl[i]));
      if (i == 12) check("lock_15", 32'(locked), 32'd0);
      if (i == 13) check("lock_16", 32'(locked), 32'd1);
    end

    // Out-of-window event drops lock on the BOTH entry
    event_(1'b1, 6);
    check("w6_pw", 32'(pulse_width), 32'd6);
    check("w6_locked", 32'(locked), 32'd0);

    // Relock
    for (int i = 0; i < LOCK_COUNT; i++) event_(1'b0, 2);
    check("relock", 32'(locked), 32'd1);

    // enable low during DN
    repeat (4) cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    check("en_dn_cur", 32'(current_out), 32'h7F000);
    check("en_dn_locked", 32'(locked), 32'd1);
    enable = 1'b0;
    cyc(1'b0, 1'b1);
    check("en_off_cur", 32'(current_out), 32'd0);
    check("en_off_dn", 32'(dn), 32'd0);
    check("en_off_locked", 32'(locked), 32'd0);
    check("en_off_pw", 32'(pulse_width), 32'd2);
    enable = 1'b1;
    cyc(1'b0, 1'b0);

    // Reference rise during BOTH is dropped
    repeat (4) cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1);
    check("drop_both", 32'({up, dn}), 32'd3);
    cyc(1'b1, 1'b1);
    check("drop_exit", 32'({up, dn}), 32'd0);
    check("drop_pw", 32'(pulse_width), 32'd1);
    cyc(1'b1, 1'b1);
    check("drop_not_up", 32'(up), 32'd0);

    // Reset in the second UP cycle
    repeat (4) cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    check("rst_up2", 32'(current_out), 32'd4096);
    reset = 1'b1;
    cyc(1'b1, 1'b0);
    check("rst_cur", 32'(current_out), 32'd0);
    check("rst_up", 32'(up), 32'd0);
    check("rst_pw", 32'(pulse_width), 32'd0);
    reset = 1'b0;
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    check("rst_rel_up", 32'(up), 32'd0);

    @(posedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
